key_event_queue: RTL and testbench

//  Consumer stage for the key-scan block. Captures each key-event strobe and its 32-bit event word into a FIFO.

---
 rtl/key_event_queue_pkg.sv | 14 +
 rtl/key_event_queue_fifo.sv | 62 ++++++
 rtl/key_event_queue.sv | 96 +++++++++
 tb/tb_key_event_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_queue_pkg.sv
// Shared constants for the key event queue: register addresses, STATUS/CTRL bit positions
// and the key-event opcode.
package key_event_queue_pkg;
    localparam logic [1:0] KEYQ_A_DATA   = 2'd0;
    localparam logic [1:0] KEYQ_A_STATUS = 2'd1;
    localparam logic [1:0] KEYQ_A_CTRL   = 2'd2;
    localparam logic [1:0] KEYQ_A_RSVD   = 2'd3;

    localparam int KEYQ_ST_OVF      = 31;
    localparam int KEYQ_CTRL_IRQ_EN = 0;
    localparam int KEYQ_CTRL_FLUSH  = 1;

    localparam logic [7:0] KEYQ_OP_KEY = 8'd1;
endpackage

// File: rtl/key_event_queue_fifo.sv
// key_fifo: synchronous FIFO with push/pop/flush, occupancy count and full/empty flags.
// Pop of an empty FIFO and push into a full FIFO (without a pop) are ignored.
module key_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DW         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         head,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: key-event FIFO with a CPU register port (DATA/STATUS/CTRL) and level irq.
// Optional KEYQ_TIMESTAMP_EN replaces ev_data[23:8] with a free-running 16-bit tick at push.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ev_valid,
    input  logic [DW-1:0] ev_data,
    input  logic          bus_sel,
    input  logic [1:0]    bus_addr,
    input  logic          bus_rd,
    input  logic          bus_wr,
    input  logic [DW-1:0] bus_wdata,
    output logic [DW-1:0] bus_rdata,
    output logic          bus_ack,
    output logic          irq
);
    logic                rd_req, wr_req, ctrl_wr, pop_req, flush, ovf_evt, status_rd;
    logic                overflow, irq_en, irq_en_next;
    logic                full, empty;
    logic [DW-1:0]       head, ev_word, rdata_next;
    logic [DEPTH_LOG2:0] count, count_next;

    // Read wins over a simultaneous write.
    assign rd_req    = bus_sel & bus_rd;
    assign wr_req    = bus_sel & bus_wr & ~bus_rd;
    assign ctrl_wr   = wr_req & (bus_addr == KEYQ_A_CTRL);
    assign pop_req   = rd_req & (bus_addr == KEYQ_A_DATA);
    assign status_rd = rd_req & (bus_addr == KEYQ_A_STATUS);
    assign flush     = ctrl_wr & bus_wdata[KEYQ_CTRL_FLUSH];
    assign ovf_evt   = ev_valid & full & ~pop_req & ~flush;
    assign irq_en_next = ctrl_wr ? bus_wdata[KEYQ_CTRL_IRQ_EN] : irq_en;

`ifdef KEYQ_TIMESTAMP_EN
    logic [15:0] tick;
    always_ff @(posedge clk) begin
        if (!rst) tick <= '0;
        else      tick <= tick + 16'd1;
    end
    assign ev_word = {ev_data[31:24], tick, ev_data[7:0]};
`else
    assign ev_word = ev_data;
`endif

    key_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DW(DW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ev_valid),
        .pop        (pop_req),
        .flush      (flush),
        .wdata      (ev_word),
        .head       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        rdata_next = '0;
        if (rd_req) begin
            case (bus_addr)
                KEYQ_A_DATA:   rdata_next = empty ? '0 : head;
                KEYQ_A_STATUS: begin
                    rdata_next[KEYQ_ST_OVF] = overflow;
                    rdata_next[7:0]         = 8'(count);
                end
                KEYQ_A_CTRL:   rdata_next[KEYQ_CTRL_IRQ_EN] = irq_en;
                default:       rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            irq_en    <= 1'b0;
            bus_rdata <= '0;
            bus_ack   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            bus_rdata <= rdata_next;
            bus_ack   <= bus_sel & (bus_rd | bus_wr);
            irq_en    <= irq_en_next;
            irq       <= (count_next != '0) & irq_en_next;
            // A new overflow outranks the clear-on-read of STATUS.
            if (flush)          overflow <= 1'b0;
            else if (ovf_evt)   overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: a reference queue model predicts every acked read
// value and the irq level; the monitor pops expected values when the DUT acknowledges.
module tb_key_event_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ev_valid = 1'b0;
    logic [31:0] ev_data = '0;
    logic        bus_sel = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] expq[$];
    logic        m_ovf = 1'b0;
    logic        m_en = 1'b0;
    logic        m_irq = 1'b0;
    logic        mon_en = 1'b0;

    key_event_queue dut (
        .clk       (clk),
        .rst       (rst),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq       (irq)
    );

    always #5 clk = ~clk;

`ifdef KEYQ_TIMESTAMP_EN
    logic [15:0] tb_tick = '0;
    always @(posedge clk) begin
        if (!rst) tb_tick <= '0;
        else      tb_tick <= tb_tick + 16'd1;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_ack) begin
                if (expq.size() == 0) chk("ack_spurious", 32'd1, 32'd0);
                else                  chk("rdata", bus_rdata, expq.pop_front());
            end else begin
                if (expq.size() != 0) begin
                    chk("ack_missing", 32'd0, 32'd1);
                    void'(expq.pop_front());
                end
                chk("rdata_idle", bus_rdata, 32'd0);
            end
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // One clock of stimulus; the model predicts the read value and next state.
    task automatic step(input logic ev, input logic [31:0] evd, input logic sel,
                        input logic rd, input logic wr, input logic [1:0] addr,
                        input logic [31:0] wd);
        logic        rdq, wrq, pop, fl, ovfe;
        logic [31:0] e, stored;
        @(negedge clk);
        #1;
        ev_valid = ev; ev_data = evd; bus_sel = sel; bus_rd = rd; bus_wr = wr;
        bus_addr = addr; bus_wdata = wd;
        rdq = sel & rd;
        wrq = sel & wr & ~rd;
        e = 32'd0;
        if (rdq) begin
            case (addr)
                2'd0: e = (mq.size() != 0) ? mq[0] : 32'd0;
                2'd1: e = {m_ovf, 23'd0, 8'(mq.size())};
                2'd2: e = {31'd0, m_en};
                default: e = 32'd0;
            endcase
        end
        if (sel & (rd | wr)) expq.push_back(e);
`ifdef KEYQ_TIMESTAMP_EN
        stored = {evd[31:24], tb_tick, evd[7:0]};
`else
        stored = evd;
`endif
        pop = rdq && addr == 2'd0 && mq.size() != 0;
        fl  = wrq && addr == 2'd2 && wd[1];
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            ovfe = ev && mq.size() == 8 && !pop;
            if (pop) void'(mq.pop_front());
            if (ev && !ovfe) mq.push_back(stored);
            if (ovfe) m_ovf = 1'b1;
            else if (rdq && addr == 2'd1) m_ovf = 1'b0;
        end
        if (wrq && addr == 2'd2) m_en = wd[0];
        m_irq = (mq.size() != 0) && m_en;
    endtask

    task automatic idle();                          step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic push(input logic [31:0] d);      step(1, d, 0, 0, 0, 0, 0); endtask
    task automatic rd_reg(input logic [1:0] a);     step(0, 0, 1, 1, 0, a, 0); endtask
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d); step(0, 0, 1, 0, 1, a, d); endtask

    task automatic do_reset(input logic with_read);
        @(negedge clk);
        #1;
        rst = 1'b0;
        ev_valid = 1'b0; bus_sel = with_read; bus_rd = with_read; bus_wr = 1'b0;
        bus_addr = 2'd0;
        mq.delete(); expq.delete();
        m_ovf = 1'b0; m_en = 1'b0; m_irq = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, bus_ack}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        #1;
        rst = 1'b1; bus_sel = 1'b0; bus_rd = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);
        mon_en = 1'b1;

        // 1: irq gated by irq_en, rises after CTRL write, falls after last pop
        push(32'h0100_0004);
        idle();
        wr_reg(2'd2, 32'd1);
        rd_reg(2'd0);
        idle(); idle();

        // 2: overflow after 9 pushes, ordered drain, STATUS clear-on-read
        for (int i = 1; i <= 9; i++) push(32'h0100_0000 | i);
        rd_reg(2'd1);
        for (int i = 0; i < 8; i++) rd_reg(2'd0);
        rd_reg(2'd1);

        // 3: full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) push(32'h0100_0010 | i);
        step(1, 32'h0100_001F, 1, 1, 0, 2'd0, 0);
        rd_reg(2'd1);
        for (int i = 0; i < 8; i++) rd_reg(2'd0);

        // 4: empty reads and empty push+pop
        rd_reg(2'd0);
        rd_reg(2'd1);
        step(1, 32'h0100_0007, 1, 1, 0, 2'd0, 0);
        rd_reg(2'd1);
        rd_reg(2'd0);

        // 5: flush concurrent with a push
        for (int i = 0; i < 3; i++) push(32'h0100_0001 + i);
        step(1, 32'h0100_0015, 1, 0, 1, 2'd2, 32'd3);
        rd_reg(2'd1);

        // rd+wr together, CTRL readback, reserved address
        step(0, 0, 1, 1, 1, 2'd2, 32'd0);
        rd_reg(2'd2);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3);
        wr_reg(2'd2, 32'd0);
        rd_reg(2'd2);

        // 6: reset mid-read with 4 entries
        wr_reg(2'd2, 32'd1);
        for (int i = 0; i < 4; i++) push(32'h0100_0008 + i);
        idle();
        do_reset(1'b1);
        rd_reg(2'd1);
        idle();

`ifdef KEYQ_TIMESTAMP_EN
        begin
            logic [31:0] w0, w1;
            push(32'h0100_0003);
            for (int i = 0; i < 4; i++) idle();
            push(32'h0100_0005);
            w0 = mq[0]; w1 = mq[1];
            rd_reg(2'd0);
            rd_reg(2'd0);
            idle();
            chk("ts_delta", {16'd0, w1[23:8] - w0[23:8]}, 32'd5);
        end
`endif

        idle(); idle();
        chk("expq_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
